// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding a small word FIFO that streams encoded
// instructions to sequential imem byte addresses over a valid/ready handshake.
module instr_encoder #(
  parameter int unsigned     DEPTH     = 4,
  parameter longint unsigned BASE_ADDR = 0,
  parameter int unsigned     ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [31:0]       req_imm,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [15:0]       words_written,
  output logic              err
);

  localparam int unsigned       AW       = $clog2(DEPTH);
  localparam logic [AW:0]       LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_BASE  = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    K_R   = 3'd0,
    K_I   = 3'd1,
    K_LW  = 3'd2,
    K_SW  = 3'd3,
    K_BEQ = 3'd4,
    K_JAL = 3'd5
  } kind_e;

  logic [31:0]       r_mem [DEPTH];
  logic [AW-1:0]     r_rptr;
  logic [AW-1:0]     r_wptr;
  logic [AW:0]       r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_words;
  logic              r_err;

  logic        w_full;
  logic        w_empty;
  logic        w_legal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_word;
  logic        w_imm12_ok;
  logic        w_imm13_ok;
  logic        w_imm21_ok;

  // An immediate fits in N signed bits when every bit from N-1 upward agrees.
  assign w_imm12_ok = (&req_imm[31:11]) | ~(|req_imm[31:11]);
  assign w_imm13_ok = (&req_imm[31:12]) | ~(|req_imm[31:12]);
  assign w_imm21_ok = (&req_imm[31:20]) | ~(|req_imm[31:20]);

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a value unassigned (avoids latches).
    w_word  = '0;
    w_legal = 1'b0;
    case (req_kind)
      K_R: begin
        w_word  = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, 7'b0110011};
        w_legal = 1'b1;
      end
      K_I: begin
        w_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0010011};
        w_legal = w_imm12_ok;
      end
      K_LW: begin
        w_word  = {req_imm[11:0], req_rs1, 3'b010, req_rd, 7'b0000011};
        w_legal = w_imm12_ok;
      end
      K_SW: begin
        w_word  = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], 7'b0100011};
        w_legal = w_imm12_ok;
      end
      K_BEQ: begin
        w_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                   req_imm[4:1], req_imm[11], 7'b1100011};
        w_legal = w_imm13_ok & ~req_imm[0];
      end
      K_JAL: begin
        w_word  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                   req_rd, 7'b1101111};
        w_legal = w_imm21_ok & ~req_imm[0];
      end
      default: ;
    endcase
  end

  assign w_full    = (r_count == LP_DEPTH);
  assign w_empty   = (r_count == '0);
  assign req_ready = !w_full && !flush;
  assign w_accept  = req_valid && req_ready;
  assign w_push    = w_accept && w_legal;
  assign w_pop     = !w_empty && mem_ready;

  assign mem_valid     = !w_empty;
  assign mem_wdata     = w_empty ? 32'd0 : r_mem[r_rptr];
  assign mem_addr      = r_addr;
  assign words_written = r_words;
  assign err           = r_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_addr  <= LP_BASE;
      r_words <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_addr  <= LP_BASE;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_addr  <= r_addr + ADDR_W'(4);
        r_words <= r_words + 16'd1;
      end
      if (w_accept && !w_legal) r_err <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; the count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wptr] <= w_word;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program-loader scenarios,
// then randomized traffic against a cycle-level queue model of the spec.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, mem_valid, mem_ready, err;
  logic [2:0]  req_kind, req_funct3;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [6:0]  req_funct7;
  logic [31:0] req_imm, mem_addr, mem_wdata;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(0), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .words_written(words_written), .err(err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: queued words, next address, handshake count, sticky error.
  logic [31:0] m_q[$];
  logic [31:0] m_addr;
  logic [15:0] m_ww;
  logic        m_err;
  bit          chk_en;
  logic [31:0] hs_log[$];

  function automatic logic [31:0] ref_word(input int unsigned k, rd, rs1, rs2, f3, f7,
                                           input logic [31:0] u);
    case (k)
      0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      2: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
      3: return (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
              | ((u & 32'h1F) << 7) | 32'h23;
      4: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
              | (rs1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      5: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
              | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_legal(input int unsigned k, input int s);
    case (k)
      0:       return 1'b1;
      1, 2, 3: return (s >= -2048) && (s <= 2047);
      4:       return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      5:       return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  // Called at a falling edge with inputs driven: compare, advance model, cross one rising edge.
  task automatic tick();
    bit acc, pop;
    #1;
    if (chk_en) begin
      check("req_ready", req_ready, (m_q.size() < DEPTH) && !flush);
      check("mem_valid", mem_valid, m_q.size() != 0);
      if (m_q.size() != 0) check("mem_wdata", mem_wdata, m_q[0]);
      check("mem_addr", mem_addr, m_addr);
      check("words_written", words_written, m_ww);
      check("err", err, m_err);
    end
    if (!rst && !flush && mem_valid && mem_ready) hs_log.push_back(mem_addr);
    if (rst) begin
      m_q.delete(); m_addr = 0; m_ww = 0; m_err = 0;
    end else if (flush) begin
      m_q.delete(); m_addr = 0; m_err = 0;
    end else begin
      acc = req_valid && (m_q.size() < DEPTH);
      pop = (m_q.size() != 0) && mem_ready;
      if (pop) begin
        void'(m_q.pop_front());
        m_addr = m_addr + 4;
        m_ww   = m_ww + 1;
      end
      if (acc) begin
        if (ref_legal(req_kind, int'(req_imm)))
          m_q.push_back(ref_word(req_kind, req_rd, req_rs1, req_rs2, req_funct3,
                                 req_funct7, req_imm));
        else
          m_err = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int unsigned k, rd, rs1, rs2, f3, f7, input logic [31:0] imm);
    req_valid  = 1'b1;
    req_kind   = 3'(k);
    req_rd     = 5'(rd);
    req_rs1    = 5'(rs1);
    req_rs2    = 5'(rs2);
    req_funct3 = 3'(f3);
    req_funct7 = 7'(f7);
    req_imm    = imm;
  endtask

  task automatic do_flush();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0:       return 32'(int'($urandom_range(0, 4095)) - 2048);
      1:       return 32'(int'($urandom_range(0, 8191)) - 4096);
      2:       return 32'(int'($urandom_range(0, 2097151)) - 1048576);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc_done;
    logic [15:0] ww0;
    rst = 1'b1; flush = 1'b0; mem_ready = 1'b0;
    req_valid = 1'b0; req_kind = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
    req_funct3 = '0; req_funct7 = '0; req_imm = '0;
    chk_en = 1'b0;
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state and first cycle after reset.
    tick();
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_ready", req_ready, 1'b1);

    // addi x1,x0,5 visible one cycle after acceptance.
    set_req(1, 1, 0, 0, 0, 0, 5);
    tick();
    req_valid = 1'b0;
    check("addi_valid", mem_valid, 1'b1);
    check("addi_word", mem_wdata, 32'h00500093);
    check("addi_addr", mem_addr, 32'h0);

    // add x3,x1,x2 then sw x2,8(x1) streamed with mem_ready high.
    rst = 1'b1; tick(); rst = 1'b0;
    mem_ready = 1'b1;
    set_req(0, 3, 1, 2, 0, 0, 0);
    tick();
    check("add_word", mem_wdata, 32'h002081B3);
    check("add_addr", mem_addr, 32'h0);
    set_req(3, 0, 1, 2, 0, 0, 8);
    tick();
    check("sw_word", mem_wdata, 32'h0020A423);
    check("sw_addr", mem_addr, 32'h4);
    req_valid = 1'b0;
    tick();
    check("two_words", words_written, 16'd2);

    // Branch and jump encodings.
    mem_ready = 1'b0;
    do_flush();
    set_req(4, 0, 1, 2, 0, 0, 32'hFFFF_FFF8);
    tick();
    req_valid = 1'b0;
    check("beq_word", mem_wdata, 32'hFE208CE3);
    do_flush();
    set_req(5, 1, 0, 0, 0, 0, 2048);
    tick();
    req_valid = 1'b0;
    check("jal_word", mem_wdata, 32'h001000EF);

    // Fill the FIFO while stalled, then drain with a fifth request pending.
    do_flush();
    hs_log.delete();
    for (int i = 0; i < 4; i++) begin
      set_req(1, i + 1, i, 0, 0, 0, 32'(i * 3));
      tick();
    end
    check("full_ready", req_ready, 1'b0);
    check("full_head_addr", mem_addr, 32'h0);
    check("full_valid", mem_valid, 1'b1);
    set_req(1, 5, 4, 0, 0, 0, 12);
    mem_ready = 1'b1;
    acc_done = 1'b0;
    for (int n = 0; n < 20 && !acc_done; n++) begin
      acc_done = req_ready;
      tick();
    end
    check("fifth_accepted", acc_done, 1'b1);
    req_valid = 1'b0;
    for (int n = 0; n < 20 && hs_log.size() < 5; n++) tick();
    check("drain_count", hs_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < hs_log.size()) check($sformatf("drain_addr%0d", i), hs_log[i], 32'(i * 4));

    // Rejected requests: illegal kind, misaligned beq, out-of-range addi.
    do_flush();
    ww0 = m_ww;
    set_req(7, 1, 1, 1, 0, 0, 0);           tick();
    set_req(4, 0, 1, 2, 0, 0, 3);           tick();
    set_req(1, 1, 0, 0, 0, 0, 4096);        tick();
    req_valid = 1'b0;
    tick();
    check("rej_err", err, 1'b1);
    check("rej_valid", mem_valid, 1'b0);
    check("rej_ww", words_written, ww0);
    do_flush();
    check("flush_err", err, 1'b0);
    check("flush_addr", mem_addr, 32'h0);

    // Flush with a stalled word; a request offered during flush is not taken.
    mem_ready = 1'b0;
    set_req(1, 2, 0, 0, 0, 0, 7);
    tick();
    set_req(1, 3, 0, 0, 0, 0, 9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    check("stall_flush_valid", mem_valid, 1'b0);
    hs_log.delete();
    mem_ready = 1'b1;
    set_req(1, 4, 0, 0, 0, 0, 1);
    tick();
    req_valid = 1'b0;
    tick();
    check("post_flush_hs", hs_log.size(), 1);
    if (hs_log.size() > 0) check("post_flush_addr", hs_log[0], 32'h0);

    // Reset with a stalled word.
    mem_ready = 1'b0;
    set_req(0, 5, 6, 7, 1, 0, 0);
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stall_rst_valid", mem_valid, 1'b0);
    check("stall_rst_ww", words_written, 16'd0);
    hs_log.delete();
    mem_ready = 1'b1;
    set_req(2, 8, 9, 0, 0, 0, 32'hFFFF_F800);
    tick();
    req_valid = 1'b0;
    tick();
    check("post_rst_hs", hs_log.size(), 1);
    if (hs_log.size() > 0) check("post_rst_addr", hs_log[0], 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      rst       = ($urandom_range(0, 127) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      set_req($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127),
              rand_imm());
      req_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Encodes instruction requests (kind, registers, funct fields, immediate) into 32-bit RV32I instruction words for the six classes the core's control path decodes: R-type, I-type ALU, lw, sw, beq and jal.
- Buffers the encoded words in a small FIFO and streams them to instruction-memory write addresses with a valid/ready handshake.
- Used by the boot/program loader and by self-checking benches to build programs in imem.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- BASE_ADDR, 0: byte address of the first word written after reset or flush.
- ADDR_W, 32: width of mem_addr.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  clears the FIFO, resets the address to BASE_ADDR, clears err.
- req_valid  in  1  an encode request is present.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_kind  in  3  0 R, 1 I-ALU, 2 lw, 3 sw, 4 beq, 5 jal; 6 and 7 are illegal.
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_funct3  in  3  used by R and I-ALU only.
- req_funct7  in  7  used by R only.
- req_imm  in  32  signed immediate; byte offset for beq and jal.
- mem_valid  out  1  the head word is presented to imem.
- mem_ready  in  1  imem accepts the word.
- mem_addr  out  ADDR_W  byte address of the head word.
- mem_wdata  out  32  encoded head word.
- words_written  out  16  count of completed mem handshakes; wraps.
- err  out  1  sticky flag for a rejected request.

## Operation
Encoding, with fields listed MSB to LSB:
- R: funct7 | rs2 | rs1 | funct3 | rd | 0110011.
- I-ALU: imm[11:0] | rs1 | funct3 | rd | 0010011. Legal range -2048..2047.
- lw: imm[11:0] | rs1 | 010 | rd | 0000011. funct3 input is ignored. Legal range -2048..2047.
- sw: imm[11:5] | rs2 | rs1 | 010 | imm[4:0] | 0100011. Legal range -2048..2047.
- beq: imm[12] | imm[10:5] | rs2 | rs1 | 000 | imm[4:1] | imm[11] | 1100011. Legal range -4096..4094; imm[0] must be 0.
- jal: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | 1101111. Legal range -1048576..1048574; imm[0] must be 0.

Request handling:
- A request is rejected when its kind is illegal, its immediate is out of range, or it is misaligned.
- A rejected request still completes its handshake. It is dropped (not enqueued), err sets, and err holds until rst or flush.
- req_ready = !full && !flush.

FIFO and memory side:
- The FIFO stores encoded words.
- mem_valid = !empty. mem_wdata is the FIFO head.
- The address register starts at BASE_ADDR and adds 4 on each mem_valid && mem_ready handshake, wrapping modulo 2^ADDR_W.
- words_written increments on the same handshake.

Priority: rst > flush > normal operation.
- On flush, all FIFO contents are discarded, including a word stalled at the head.
- A push and a pop in the same cycle are both performed when the FIFO is neither empty (for the pop) nor full (for the push).

## Timing
- Reset values:
  - mem_valid 0, mem_addr BASE_ADDR, mem_wdata 0.
  - words_written 0, err 0.
  - req_ready 1 in the first cycle after rst deasserts.
  - FIFO empty.
- Latency: a request accepted at edge N into an empty FIFO gives mem_valid=1 with its word and address after edge N. There is no combinational path from req_* to mem_*.
- Throughput: one word per cycle while mem_ready=1.
- Stall: while mem_valid && !mem_ready, mem_addr and mem_wdata hold stable and mem_valid stays high.
- Full FIFO: req_ready=0 even if a pop occurs in the same cycle. It rises in the cycle after the pop.
- Flush at edge N: after N, mem_valid=0, mem_addr=BASE_ADDR, err=0. words_written is not cleared. A req_valid during the flush cycle is not accepted.
- rst mid-stream: all state returns to reset values at the next edge. A pending word is lost without a write.
- err rises in the cycle after the rejecting handshake.

## Test plan
- addi x1,x0,5 (kind 1, rd 1, rs1 0, funct3 0, imm 5) → mem_wdata 0x00500093 at mem_addr 0x0, mem_valid one cycle after accept.
- add x3,x1,x2 (kind 0, funct7 0, funct3 0) then sw x2,8(x1) (kind 3) with mem_ready=1 → 0x002081B3 at 0x0, then 0x0020A423 at 0x4; words_written=2.
- beq x1,x2,-8 (kind 4, imm 0xFFFFFFF8) → 0xFE208CE3; jal x1,+2048 (kind 5) → 0x001000EF.
- Hold mem_ready=0 and offer 5 requests:
  - 4 are accepted; req_ready=0 on the 5th.
  - Head stays stable at 0x0.
  - After releasing mem_ready: addresses 0x0, 0x4, 0x8, 0xC, then the 5th word at 0x10.
- Reject cases:
  - kind 7, beq with imm 3, and addi with imm 4096 → err=1, no mem_valid, words_written unchanged.
  - Then flush → err=0, mem_addr=BASE_ADDR.
- Flush and rst while a word is stalled (mem_ready=0) → mem_valid=0 next cycle; the following request is written at BASE_ADDR.
